// File: rtl/elevator_call_encoder_if.sv
// Hall-call encoder bus: raw buttons in, accepted floor code and status out.
//
// Handshake: o_req_valid is a one-cycle, fire-and-forget pulse with no ready
// return path. The consumer must take o_floor in the same cycle that
// o_req_valid is high. o_floor then holds its value until the next pulse.
// o_busy and o_pending are plain status levels and carry no handshake meaning.
// state_dbg mirrors the encoder FSM state (0 = IDLE, 1 = HOLD) for observation.
interface elevator_call_encoder_if;
  logic [2:0] i_call;
  logic [1:0] o_floor;
  logic       o_req_valid;
  logic       o_busy;
  logic       o_pending;
  logic       state_dbg;

  // Encoder side.
  modport master (
    input  i_call,
    output o_floor,
    output o_req_valid,
    output o_busy,
    output o_pending,
    output state_dbg
  );

  // Button/consumer side.
  modport slave (
    output i_call,
    input  o_floor,
    input  o_req_valid,
    input  o_busy,
    input  o_pending,
    input  state_dbg
  );
endinterface

// File: rtl/elevator_call_encoder.sv
// elevator_call_encoder: synchronizes and debounces three hall-call buttons.
// It turns debounced presses into a 2-bit floor code and enforces a minimum
// hold window per accepted call. One call arriving during that window is
// queued, and a later call replaces the queued one.
//
// Optional build macro ELEV_SAME_FLOOR_FILTER_EN: when defined, calls for the
// floor already on o_floor are ignored. Such calls are not accepted and are not
// queued, and a queued call equal to o_floor is dropped when the hold expires.
module elevator_call_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,  // min 2
  parameter int HOLD_CYCLES     = 64   // min 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  elevator_call_encoder_if.master       bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Input conditioning.
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_level_q;
  logic [2:0]    deb_level_d_q;
  logic [CW-1:0] deb_cnt_q [3];

  // Press detection and arbitration.
  logic [2:0] press;
  logic       press_any;
  logic [1:0] winner;
  logic       strobe_ok;
  logic       pend_ok;

  // FSM and registered outputs.
  state_t        state_q;
  logic [HW-1:0] hold_cnt_q;
  logic [1:0]    floor_q;
  logic          req_q;
  logic          busy_q;
  logic          pend_valid_q;
  logic [1:0]    pend_floor_q;

  // Two-flop synchronizer per button; the raw inputs are asynchronous.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.i_call;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: the level flips only after the synced sample has
  // disagreed with it for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      deb_level_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_level_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_level_q[i] <= ~deb_level_q[i];
          deb_cnt_q[i]   <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced levels for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      deb_level_d_q <= '0;
    end else begin
      deb_level_d_q <= deb_level_q;
    end
  end

  // Press strobe: one cycle per debounced 0->1 transition; releases are ignored.
  always_comb begin
    press     = deb_level_q & ~deb_level_d_q;
    press_any = |press;
    winner    = 2'd0;
    if (press[0]) begin
      winner = 2'd0;
    end else if (press[1]) begin
      winner = 2'd1;
    end else if (press[2]) begin
      winner = 2'd2;
    end
  end

`ifdef ELEV_SAME_FLOOR_FILTER_EN
  // Calls for the floor already being served are dropped.
  assign strobe_ok = press_any && (winner != floor_q);
  assign pend_ok   = pend_valid_q && (pend_floor_q != floor_q);
`else
  // Every winning press is accepted, even if it repeats the current floor.
  assign strobe_ok = press_any;
  assign pend_ok   = pend_valid_q;
`endif

  // Call FSM: accept in IDLE, then hold o_floor for HOLD_CYCLES while queueing
  // the latest call. At hold expiry a fresh strobe beats an older queued call.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      floor_q      <= 2'd0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_floor_q <= 2'd0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (strobe_ok) begin
            floor_q    <= winner;
            req_q      <= 1'b1;
            hold_cnt_q <= HOLD_LAST;
            busy_q     <= 1'b1;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) begin
            if (strobe_ok) begin
              floor_q      <= winner;
              req_q        <= 1'b1;
              hold_cnt_q   <= HOLD_LAST;
              pend_valid_q <= 1'b0;
            end else if (pend_ok) begin
              floor_q      <= pend_floor_q;
              req_q        <= 1'b1;
              hold_cnt_q   <= HOLD_LAST;
              pend_valid_q <= 1'b0;
            end else begin
              busy_q       <= 1'b0;
              pend_valid_q <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - HW'(1);
            if (strobe_ok) begin
              pend_floor_q <= winner;
              pend_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  assign bus.o_floor     = floor_q;
  assign bus.o_req_valid = req_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_pending   = pend_valid_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_elevator_call_encoder.sv
// Bench for elevator_call_encoder with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// A time-based reference model predicts the outputs every cycle. Directed
// scenarios pin absolute latencies, priorities, queueing and reset behaviour.
module tb_elevator_call_encoder;
  localparam int D = 4;
  localparam int H = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  elevator_call_encoder_if bus ();

  elevator_call_encoder #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         edge_n     = 0;
  logic [2:0] raw_d1     = '0;
  logic [2:0] raw_d2     = '0;
  logic [2:0] lvl        = '0;
  int         run [3]    = '{0, 0, 0};
  logic [2:0] m_press    = '0;
  int         m_floor    = 0;
  bit         m_req      = 0;
  bit         m_busy     = 0;
  bit         m_pend_v   = 0;
  int         m_pend_f   = 0;
  int         m_hold_end = 0;

  task automatic m_accept(input int f);
    m_floor    = f;
    m_req      = 1;
    m_busy     = 1;
    m_pend_v   = 0;
    m_hold_end = edge_n + H;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n   = 0;
      raw_d1   = '0;
      raw_d2   = '0;
      lvl      = '0;
      for (int f = 0; f < 3; f++) run[f] = 0;
      m_press  = '0;
      m_floor  = 0;
      m_req    = 0;
      m_busy   = 0;
      m_pend_v = 0;
      m_pend_f = 0;
    end else begin
      bit have;
      bit pend_use;
      int win;
      edge_n++;
      m_req = 0;
      have  = 0;
      win   = 0;
      for (int f = 0; f < 3; f++) begin
        if (!have && m_press[f]) begin
          have = 1;
          win  = f;
        end
      end
      pend_use = m_pend_v;
`ifdef ELEV_SAME_FLOOR_FILTER_EN
      if (have && win == m_floor) have = 0;
      if (m_pend_f == m_floor) pend_use = 0;
`endif
      if (!m_busy) begin
        if (have) m_accept(win);
      end else if (edge_n == m_hold_end) begin
        if (have) m_accept(win);
        else if (pend_use) m_accept(m_pend_f);
        else begin
          m_busy   = 0;
          m_pend_v = 0;
        end
      end else if (have) begin
        m_pend_v = 1;
        m_pend_f = win;
      end
      // Debounce: level follows the synced sample after D disagreeing samples.
      m_press = '0;
      for (int f = 0; f < 3; f++) begin
        if (raw_d2[f] != lvl[f]) begin
          run[f]++;
          if (run[f] == D) begin
            lvl[f] = raw_d2[f];
            run[f] = 0;
            if (lvl[f]) m_press[f] = 1'b1;
          end
        end else begin
          run[f] = 0;
        end
      end
      raw_d2 = raw_d1;
      raw_d1 = bus.i_call;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("floor",     32'(bus.o_floor),     32'(m_floor));
      check("req_valid", 32'(bus.o_req_valid), 32'(m_req));
      check("busy",      32'(bus.o_busy),      32'(m_busy));
      check("pending",   32'(bus.o_pending),   32'(m_pend_v));
      check("state_dbg", 32'(bus.state_dbg),   32'(m_busy));
      check("floor_code_range", 32'(bus.o_floor != 2'b11), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pulse(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.o_req_valid && k < limit);
    check("pulse_seen", 32'(bus.o_req_valid), 32'd1);
  endtask

  task automatic quiet(input int cycles);
    bus.i_call = 3'b000;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int cnt;
    int pulses;
    bus.i_call = 3'b000;

    // Asynchronous reset with no clock edge in between.
    #1 rst = 1'b1;
    #1;
    check("rst_floor",   32'(bus.o_floor),     32'd0);
    check("rst_req",     32'(bus.o_req_valid), 32'd0);
    check("rst_busy",    32'(bus.o_busy),      32'd0);
    check("rst_pending", 32'(bus.o_pending),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Glitch shorter than the debounce window.
    bus.i_call = 3'b010;
    repeat (3) @(negedge clk);
    bus.i_call = 3'b000;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_req_valid) pulses++;
    end
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_floor",  32'(bus.o_floor), 32'd0);

    // Held floor-2 button: pulse at the 7th edge, 8-cycle hold, single accept.
    bus.i_call = 3'b100;
    wait_pulse(40, k);
    check("latency_edges", 32'(k), 32'd7);
    check("held_floor",    32'(bus.o_floor), 32'd2);
    cnt = 0;
    while (bus.o_busy && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(cnt), 32'd8);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_req_valid) pulses++;
    end
    check("held_repulse", 32'(pulses), 32'd0);
    quiet(25);

    // Accept floor 1, queue floor 2, overwrite with floor 0, served at expiry.
    bus.i_call = 3'b010;
    for (int s = 1; s <= 24; s++) begin
      @(negedge clk);
      if (s == 7) begin
        check("q_accept_req",   32'(bus.o_req_valid), 32'd1);
        check("q_accept_floor", 32'(bus.o_floor),     32'd1);
      end
      if (s == 10) check("q_pending", 32'(bus.o_pending), 32'd1);
      if (s == 15) begin
        check("q_expiry_req",     32'(bus.o_req_valid), 32'd1);
        check("q_expiry_floor",   32'(bus.o_floor),     32'd0);
        check("q_expiry_pending", 32'(bus.o_pending),   32'd0);
      end
      if (s == 22) check("q_busy_still", 32'(bus.o_busy), 32'd1);
      if (s == 23) check("q_busy_done",  32'(bus.o_busy), 32'd0);
      if (s == 2) bus.i_call = 3'b110;
      if (s == 4) bus.i_call = 3'b111;
    end
    quiet(25);

    // Simultaneous floors 1 and 2: lowest index wins, the other is dropped.
    bus.i_call = 3'b110;
    wait_pulse(40, k);
    check("prio_floor", 32'(bus.o_floor), 32'd1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_pending) cnt++;
    end
    check("prio_no_pending", 32'(cnt), 32'd0);
    quiet(25);

    // Same-floor call while idle with o_floor already 1.
    bus.i_call = 3'b010;
    pulses = 0;
    cnt    = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_req_valid) pulses++;
      if (bus.o_busy) cnt++;
    end
`ifdef ELEV_SAME_FLOOR_FILTER_EN
    check("same_pulses", 32'(pulses), 32'd0);
    check("same_busy",   32'(cnt),    32'd0);
`else
    check("same_pulses", 32'(pulses), 32'd1);
    check("same_busy",   32'(cnt),    32'd8);
`endif
    check("same_floor", 32'(bus.o_floor), 32'd1);
    quiet(25);

    // Randomized button activity against the model.
    for (int s = 0; s < 250; s++) begin
      bus.i_call = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    quiet(30);

    // Reset in the middle of a hold window.
    bus.i_call = 3'b100;
    wait_pulse(40, k);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midhold_floor",   32'(bus.o_floor),     32'd0);
    check("midhold_req",     32'(bus.o_req_valid), 32'd0);
    check("midhold_busy",    32'(bus.o_busy),      32'd0);
    check("midhold_pending", 32'(bus.o_pending),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    quiet(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
